// File: rtl/adc_pkg.sv
// Shared types and default geometry for the SPI-attached SAR ADC responder model.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        CONV  = 2'd2,
        TRAIL = 2'd3
    } adc_state_e;

    localparam int DEF_RES_BITS   = 12;
    localparam int DEF_LEAD_ZEROS = 4;
    localparam int FRAME_LEN      = DEF_LEAD_ZEROS + DEF_RES_BITS;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous pin followed by an edge-detect flop.
module sync_edge_det #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              edge_q, edge_d;

    // Shift the pin into the chain; the edge flop trails the last sync stage.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        edge_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-detect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            edge_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end

    // Pulses are decoded from flops only, so they are glitch-free single-cycle strobes.
    assign rise = sync_q[STAGES-1] & ~edge_q;
    assign fall = ~sync_q[STAGES-1] & edge_q;

endmodule

// File: rtl/sar_adc_spi_target.sv
// SPI mode-0 responder modelling a SAR ADC: samples at CS fall, resolves one bit per SCLK fall.
module sar_adc_spi_target
    import adc_pkg::*;
#(
    parameter int RES_BITS    = DEF_RES_BITS,
    parameter int LEAD_ZEROS  = DEF_LEAD_ZEROS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RES_BITS-1:0] analog_volts,
    input  logic                spi_sclk,
    input  logic                spi_cs_n,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    output logic                busy,
    output logic                conv_done,
    output logic [RES_BITS-1:0] result,
    output logic [15:0]         frame_count
);

    localparam int FRAME_BITS = LEAD_ZEROS + RES_BITS;
    localparam int KW         = $clog2(FRAME_BITS + 1);
    localparam int IW         = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;
    localparam logic [KW-1:0] LAST_K  = KW'(FRAME_BITS - 1);
    localparam logic [KW-1:0] FIRST_C = KW'(LEAD_ZEROS);
    localparam logic [RES_BITS-1:0] ONE_HOT0 = {{(RES_BITS-1){1'b0}}, 1'b1};

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (spi_cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    adc_state_e          state_q, state_d;
    logic [RES_BITS-1:0] held_q, held_d;
    logic [RES_BITS-1:0] sar_q, sar_d;
    logic [KW-1:0]       bitpos_q, bitpos_d;
    logic                miso_q, miso_d;
    logic                oe_q, oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [RES_BITS-1:0] result_q, result_d;
    logic [15:0]         count_q, count_d;

    logic [KW-1:0]       k_next;
    logic [IW-1:0]       bit_idx;
    logic [RES_BITS-1:0] trial_mask;
    logic                decision;

    // Frame sequencing and the per-bit SAR trial/decision.
    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        sar_d      = sar_q;
        bitpos_d   = bitpos_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        count_d    = count_q;
        k_next     = bitpos_q + KW'(1);
        bit_idx    = IW'(FRAME_BITS - 1 - int'(k_next));
        trial_mask = ONE_HOT0 << bit_idx;
        // sar bit under trial is still 0, so OR-ing the mask forms the trial code.
        decision   = (held_q >= (sar_q | trial_mask));

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    held_d   = analog_volts;
                    sar_d    = '0;
                    bitpos_d = '0;
                    busy_d   = 1'b1;
                    oe_d     = 1'b1;
                    miso_d   = 1'b0;
                    state_d  = LEAD;
                end else begin
                    state_d  = IDLE;
                end
            end
            LEAD, CONV: begin
                if (cs_rise) begin
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (state_q == CONV && sclk_rise && bitpos_q == LAST_K) begin
                    result_d = sar_q;
                    count_d  = count_q + 16'd1;
                    done_d   = 1'b1;
                    state_d  = TRAIL;
                end else if (sclk_fall && bitpos_q != LAST_K) begin
                    bitpos_d = k_next;
                    if (k_next < FIRST_C) begin
                        miso_d = 1'b0;
                    end else begin
                        sar_d   = decision ? (sar_q | trial_mask) : sar_q;
                        miso_d  = decision;
                        state_d = CONV;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            TRAIL: begin
                if (cs_rise) begin
                    busy_d  = 1'b0;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_fall) begin
                    miso_d  = 1'b0;
                end else begin
                    state_d = TRAIL;
                end
            end
            default: begin
                busy_d  = 1'b0;
                oe_d    = 1'b0;
                miso_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            held_q   <= '0;
            sar_q    <= '0;
            bitpos_q <= '0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            count_q  <= 16'd0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            sar_q    <= sar_d;
            bitpos_q <= bitpos_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign busy        = busy_q;
    assign conv_done   = done_q;
    assign result      = result_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_sar_adc_spi_target.sv
// Bench for sar_adc_spi_target: acts as the SPI master and compares against an ideal-ADC model.
module tb_sar_adc_spi_target;
    import adc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] analog_volts;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        busy;
    logic        conv_done;
    logic [11:0] result;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    sar_adc_spi_target dut (
        .clk          (clk),
        .reset        (reset),
        .analog_volts (analog_volts),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .busy         (busy),
        .conv_done    (conv_done),
        .result       (result),
        .frame_count  (frame_count)
    );

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    // Reference model state: an ideal ADC returns the held sample exactly.
    logic [15:0] m_count;
    logic [11:0] m_result;

    always @(negedge clk) begin
        if (conv_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One master transaction: nclk SCLK periods (clk/10), optionally aborted or with a mid-frame input change.
    task automatic run_frame(input string tag, input logic [11:0] v, input int nclk, input int abort_after,
                             input int chg_at, input logic [11:0] chg_v);
        logic [31:0] word;
        logic [31:0] full;
        logic [31:0] exp_word;
        int          n;
        int          d0;
        bit          complete;
        word = 32'd0;
        analog_volts = v;
        d0 = done_cnt;
        n = (abort_after < nclk) ? abort_after : nclk;
        complete = (n >= FRAME_LEN);
        spi_cs_n = 1'b0;
        tick(5);
        check({tag, "_oe_active"}, {31'd0, spi_miso_oe}, 32'd1);
        check({tag, "_busy_active"}, {31'd0, busy}, 32'd1);
        for (int k = 0; k < n; k++) begin
            word = {word[30:0], spi_miso};
            spi_sclk = 1'b1;
            tick(5);
            if (k + 1 == chg_at) analog_volts = chg_v;
            spi_sclk = 1'b0;
            tick(5);
        end
        spi_cs_n = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tick(1);
            if (busy === 1'b0 && spi_miso_oe === 1'b0) break;
        end
        check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
        check({tag, "_oe_drop"}, {31'd0, spi_miso_oe}, 32'd0);
        tick(4);
        full = {20'd0, v};
        exp_word = (n <= FRAME_LEN) ? (full >> (FRAME_LEN - n)) : (full << (n - FRAME_LEN));
        if (complete) begin
            m_count  = m_count + 16'd1;
            m_result = v;
        end
        check({tag, "_miso_stream"}, word, exp_word);
        check({tag, "_done_pulses"}, done_cnt - d0, complete ? 32'd1 : 32'd0);
        check({tag, "_result"}, {20'd0, result}, {20'd0, m_result});
        check({tag, "_frame_count"}, {16'd0, frame_count}, {16'd0, m_count});
        check({tag, "_oe_idle"}, {31'd0, spi_miso_oe}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
        check({tag, "_oe"}, {31'd0, spi_miso_oe}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, conv_done}, 32'd0);
        check({tag, "_result"}, {20'd0, result}, 32'd0);
        check({tag, "_count"}, {16'd0, frame_count}, 32'd0);
    endtask

    initial begin
        logic [11:0] rv;
        int          rn;
        int          ra;
        reset        = 1'b1;
        spi_cs_n     = 1'b1;
        spi_sclk     = 1'b0;
        analog_volts = 12'd0;
        m_count      = 16'd0;
        m_result     = 12'd0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(5);

        run_frame("v2500", 12'd2500, 16, 99, 0, 12'd0);
        run_frame("v0", 12'd0, 16, 99, 0, 12'd0);
        run_frame("v4095", 12'd4095, 16, 99, 0, 12'd0);
        run_frame("hold1000", 12'd1000, 16, 99, 6, 12'd3000);
        run_frame("next3000", 12'd3000, 16, 99, 0, 12'd0);
        run_frame("abort2000", 12'd2000, 16, 9, 0, 12'd0);

        // Reset during CONV, then a clean frame.
        analog_volts = 12'd777;
        spi_cs_n = 1'b0;
        tick(5);
        for (int k = 0; k < 7; k++) begin
            spi_sclk = 1'b1;
            tick(5);
            spi_sclk = 1'b0;
            tick(5);
        end
        reset    = 1'b1;
        spi_cs_n = 1'b1;
        tick(1);
        check_all_zero("midreset");
        reset    = 1'b0;
        m_count  = 16'd0;
        m_result = 12'd0;
        tick(5);
        run_frame("post_reset1234", 12'd1234, 16, 99, 0, 12'd0);

        run_frame("long3000", 12'd3000, 20, 99, 0, 12'd0);

        for (int r = 0; r < 8; r++) begin
            rv = 12'($urandom_range(0, 4095));
            rn = 16 + int'($urandom_range(0, 4));
            ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 99;
            run_frame($sformatf("rand%0d", r), rv, rn, ra, 0, 12'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
